// File: rtl/bubble_sort_core_if.sv
// Operand load, sorted register bank and ready/valid readout bundle of the
// bubble sort core.
interface bubble_sort_core_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic                  busy;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;
  logic [DATA_WIDTH-1:0] d2;
  logic [DATA_WIDTH-1:0] d3;
  logic [1:0]            sel;
  logic                  out_valid;
  logic                  out_ready;
  logic                  done;

  modport master (
    output start, din0, din1, din2, din3, out_ready,
    input  busy, d0, d1, d2, d3, sel, out_valid, done
  );

  modport slave (
    input  start, din0, din1, din2, din3, out_ready,
    output busy, d0, d1, d2, d3, sel, out_valid, done
  );
endinterface

// File: rtl/bubble_sort_core.sv
// Four-entry unsigned in-place bubble sort, one compare-swap per clock, with a
// ready/valid readout stepping the downstream mux select.
// BUBBLE_SORT_EARLY_EXIT_EN: finish COMPARE after the first pass with no swaps.
module bubble_sort_core #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  bubble_sort_core_if.slave  sort_if
);

  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    READOUT = 2'd2
  } state_e;

  typedef logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] bank_t;

  state_e     state_q,     state_d;
  bank_t      slot_q,      slot_d;
  logic [1:0] pass_q,      pass_d;
  logic [1:0] pair_q,      pair_d;
  logic [1:0] sel_q,       sel_d;
  logic       busy_q,      busy_d;
  logic       out_valid_q, out_valid_d;
  logic       done_q,      done_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic       swap_q,      swap_d;
`endif

  logic [1:0]            pair_hi_c;
  logic [DATA_WIDTH-1:0] lo_c;
  logic [DATA_WIDTH-1:0] hi_c;
  logic                  swap_now_c;
  logic                  last_pair_c;
  logic                  exit_c;

  // Compare datapath for the pair currently addressed
  always_comb begin
    pair_hi_c   = 2'(pair_q + 2'd1);
    lo_c        = slot_q[pair_q];
    hi_c        = slot_q[pair_hi_c];
    swap_now_c  = (lo_c > hi_c);
    last_pair_c = (pair_q == 2'(2'd2 - pass_q));
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    exit_c      = (pass_q == 2'd2) || !(swap_q || swap_now_c);
`else
    exit_c      = (pass_q == 2'd2);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      pass_q      <= 2'd0;
      pair_q      <= 2'd0;
      sel_q       <= 2'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pass_q      <= pass_d;
      pair_q      <= pair_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swap_q      <= swap_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pass_d      = pass_q;
    pair_d      = pair_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    swap_d      = swap_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sort_if.start) begin
          slot_d  = {sort_if.din3, sort_if.din2, sort_if.din1, sort_if.din0};
          pass_d  = 2'd0;
          pair_d  = 2'd0;
          busy_d  = 1'b1;
          state_d = COMPARE;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          swap_d  = 1'b0;
`endif
        end
      end

      COMPARE: begin
        if (swap_now_c) begin
          slot_d[pair_q]    = hi_c;
          slot_d[pair_hi_c] = lo_c;
        end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        swap_d = swap_q | swap_now_c;
`endif
        if (last_pair_c) begin
          pair_d = 2'd0;
          pass_d = 2'(pass_q + 2'd1);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          swap_d = 1'b0;
`endif
          if (exit_c) begin
            state_d     = READOUT;
            sel_d       = 2'd0;
            out_valid_d = 1'b1;
          end
        end else begin
          pair_d = pair_hi_c;
        end
      end

      READOUT: begin
        // out_valid is always high here, so out_ready alone marks a transfer
        if (sort_if.out_ready) begin
          if (sel_q == 2'd3) begin
            state_d     = IDLE;
            sel_d       = 2'd0;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            sel_d = 2'(sel_q + 2'd1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sort_if.busy      = busy_q;
  assign sort_if.d0        = slot_q[0];
  assign sort_if.d1        = slot_q[1];
  assign sort_if.d2        = slot_q[2];
  assign sort_if.d3        = slot_q[3];
  assign sort_if.sel       = sel_q;
  assign sort_if.out_valid = out_valid_q;
  assign sort_if.done      = done_q;

endmodule
